pq_sreg_param: RTL and testbench

- Parametrised shift-register hardware priority queue; next generation of the fixed-width HWPQ devices.
- Key width, value width, depth and min/max ordering are configurable. Adds an empty flag, an occupancy count, synchronous clear, simultaneous pop+push (replace) and stable FIFO ordering among equal keys.
- Implements the standard HWPQ device-side handshake (ivalid/irdy, ovalid/ordy, busy, full) and sits behind any HWPQ client.

---
 rtl/pq_sreg_param.sv | 129 ++++++++++++
 tb/tb_pq_sreg_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pq_sreg_param.sv
// +--------------------------------------------------------------------------+
// | pq_sreg_param : parametrised sorted shift-register priority queue.       |
// | Optional rejected-insert counter enabled by defining PQ_DROP_CNT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pq_sreg_param #(
  parameter int KEY_W     = 8,
  parameter int VAL_W     = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_FIRST = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ivalid,
  output logic                           irdy,
  input  logic [KEY_W+VAL_W-1:0]         idata,
  input  logic                           clear,
  output logic                           busy,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           ovalid,
  input  logic                           ordy,
  output logic [KEY_W+VAL_W-1:0]         odata,
  output logic [15:0]                    drop_cnt
);

  localparam int W  = KEY_W + VAL_W;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  ent_q [DEPTH];
  logic [W-1:0]  ent_d [DEPTH];
  logic [W-1:0]  ent_prv [DEPTH];
  logic [W-1:0]  ent_nxt [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic [DEPTH-1:0] ge, ge_prv, ge_nxt;
  logic          push, pop;

  // True when key a must stay ahead of key b (ties keep the older entry first).
  function automatic logic prio_ge(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    if (MAX_FIRST != 0) return a >= b;
    else                return a <= b;
  endfunction

  assign busy   = busy_q;
  assign count  = count_q;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign ovalid = !empty && !busy_q;
  assign irdy   = !busy_q && (!full || (ovalid && ordy));
  assign odata  = ent_q[0];
  assign push   = ivalid && irdy;
  assign pop    = ovalid && ordy;

  always_comb begin
    ge = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ge[i] = (CW'(i) < count_q) && prio_ge(ent_q[i][W-1 -: KEY_W], idata[W-1 -: KEY_W]);
    end
    ge_prv = {ge[DEPTH-2:0], 1'b1};
    ge_nxt = {1'b0, ge[DEPTH-1:1]};
    ent_prv[0]       = '0;
    ent_nxt[DEPTH-1] = '0;
    for (int i = 1; i < DEPTH; i++) ent_prv[i]   = ent_q[i-1];
    for (int i = 0; i < DEPTH-1; i++) ent_nxt[i] = ent_q[i+1];
  end

  always_comb begin
    busy_d  = clear;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    if (clear) begin
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
    end else if (push && pop) begin
      // Head leaves; insert into the remaining entries viewed one slot forward.
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = ge_nxt[i] ? ent_nxt[i] : (((i == 0) || ge[i]) ? idata : ent_q[i]);
      end
    end else if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = ge[i] ? ent_q[i] : (ge_prv[i] ? idata : ent_prv[i]);
      end
      count_d = count_q + 1'b1;
    end else if (pop) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_nxt[i];
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= 1'b1;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

`ifdef PQ_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (clear)
      drop_d = '0;
    else if (!busy_q && ivalid && !irdy && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pq_sreg_param.sv
// +--------------------------------------------------------------------------+
// | tb_pq_sreg_param : scoreboard bench for pq_sreg_param (min and max).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pq_sreg_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, ivalid, ordy;
  logic [15:0] idata;
  logic        irdy, busy, full, empty, ovalid;
  logic [4:0]  count;
  logic [15:0] odata, drop_cnt;

  logic        clear_m, ivalid_m, ordy_m;
  logic [15:0] idata_m;
  logic        irdy_m, busy_m, full_m, empty_m, ovalid_m;
  logic [4:0]  count_m;
  logic [15:0] odata_m, drop_cnt_m;

  pq_sreg_param #(.KEY_W(8), .VAL_W(8), .DEPTH(16), .MAX_FIRST(0)) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .irdy(irdy), .idata(idata),
    .clear(clear), .busy(busy), .full(full), .empty(empty), .count(count),
    .ovalid(ovalid), .ordy(ordy), .odata(odata), .drop_cnt(drop_cnt)
  );

  pq_sreg_param #(.KEY_W(8), .VAL_W(8), .DEPTH(16), .MAX_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .ivalid(ivalid_m), .irdy(irdy_m), .idata(idata_m),
    .clear(clear_m), .busy(busy_m), .full(full_m), .empty(empty_m), .count(count_m),
    .ovalid(ovalid_m), .ordy(ordy_m), .odata(odata_m), .drop_cnt(drop_cnt_m)
  );

  int          nvec = 0;
  int          nbad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] expm_q[$];
  logic [15:0] e_v, em_v;

`ifdef PQ_DROP_CNT_EN
  localparam logic [15:0] DROP_EXP = 16'd5;
`else
  localparam logic [15:0] DROP_EXP = 16'd0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitors: every accepted pop is compared with the next scoreboard entry.
  always @(negedge clk) begin
    if (rst && ovalid && ordy) begin
      if (exp_q.size() == 0) begin
        nvec++; nbad++;
        $display("FAIL pop_unexpected: got %h expected none", odata);
      end else begin
        e_v = exp_q.pop_front();
        chk("pop_data", odata, e_v);
      end
    end
    if (rst && ovalid_m && ordy_m) begin
      if (expm_q.size() == 0) begin
        nvec++; nbad++;
        $display("FAIL popm_unexpected: got %h expected none", odata_m);
      end else begin
        em_v = expm_q.pop_front();
        chk("popm_data", odata_m, em_v);
      end
    end
  end

  task automatic push(input logic [7:0] k, input logic [7:0] v);
    idata = {k, v}; ivalid = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b0;
  endtask

  task automatic pop(input logic [7:0] k, input logic [7:0] v);
    exp_q.push_back({k, v}); ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask

  task automatic pushpop(input logic [7:0] k, input logic [7:0] v,
                         input logic [7:0] ek, input logic [7:0] ev);
    exp_q.push_back({ek, ev});
    idata = {k, v}; ivalid = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b0; ordy = 1'b0;
  endtask

  task automatic push_m(input logic [7:0] k, input logic [7:0] v);
    idata_m = {k, v}; ivalid_m = 1'b1;
    @(posedge clk); #1;
    ivalid_m = 1'b0;
  endtask

  task automatic pop_m(input logic [7:0] k, input logic [7:0] v);
    expm_q.push_back({k, v}); ordy_m = 1'b1;
    @(posedge clk); #1;
    ordy_m = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; ivalid = 1'b0; ordy = 1'b0; idata = '0;
    clear_m = 1'b0; ivalid_m = 1'b0; ordy_m = 1'b0; idata_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  busy, 1);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_irdy",  irdy, 0);
    chk("rst_odata", odata, 0);
    chk("rst_drop",  drop_cnt, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("init_busy", busy, 0);
    chk("init_irdy", irdy, 1);

    // Basic ordering, smallest key first
    push(8'd5, 8'h50); push(8'd2, 8'h20); push(8'd9, 8'h90);
    chk("t1_count", count, 3);
    chk("t1_head",  odata, 16'h0220);
    pop(8'd2, 8'h20); pop(8'd5, 8'h50); pop(8'd9, 8'h90);
    chk("t1_empty", empty, 1);
    chk("t1_count0", count, 0);
    chk("t1_ovalid", ovalid, 0);

    // Equal keys leave in insertion order
    push(8'd3, 8'hA1); push(8'd3, 8'hB2);
    pop(8'd3, 8'hA1); pop(8'd3, 8'hB2);

    // Fill, then replace at full
    for (int i = 0; i < 16; i++) push(8'(10 + i), 8'(i));
    chk("t3_full",  full, 1);
    chk("t3_count", count, 16);
    chk("t3_irdy_full", irdy, 0);
    ordy = 1'b1; #1;
    chk("t3_irdy_pop", irdy, 1);
    pushpop(8'd0, 8'hEE, 8'd10, 8'h00);
    chk("t3_count_rep", count, 16);
    chk("t3_head_rep",  odata, 16'h00EE);

    // Rejected inserts while full
    idata = 16'h0101; ivalid = 1'b1;
    repeat (5) @(posedge clk);
    #1; ivalid = 1'b0;
    chk("t6_drop", drop_cnt, DROP_EXP);
    chk("t6_count", count, 16);

    pop(8'd0, 8'hEE);
    for (int i = 1; i < 16; i++) pop(8'(10 + i), 8'(i));
    chk("t3_drained", empty, 1);

    // Clear with a simultaneous insert
    for (int i = 0; i < 4; i++) push(8'(i * 4), 8'(i));
    chk("t5_count4", count, 4);
    clear = 1'b1; ivalid = 1'b1; idata = 16'h0077;
    @(posedge clk); #1;
    clear = 1'b0; ivalid = 1'b0;
    chk("t5_busy",   busy, 1);
    chk("t5_count",  count, 0);
    chk("t5_ovalid", ovalid, 0);
    chk("t5_irdy",   irdy, 0);
    chk("t5_odata",  odata, 0);
    chk("t5_drop",   drop_cnt, 0);
    @(posedge clk); #1;
    chk("t5_busy_done", busy, 0);
    chk("t5_empty",  empty, 1);
    push(8'h42, 8'h42);
    pop(8'h42, 8'h42);

    // Largest key first instance
    push_m(8'h10, 8'h01); push_m(8'hF0, 8'h02); push_m(8'h80, 8'h03);
    chk("t4_head", odata_m, 16'hF002);
    chk("t4_count", count_m, 3);
    pop_m(8'hF0, 8'h02); pop_m(8'h80, 8'h03); pop_m(8'h10, 8'h01);
    chk("t4_empty", empty_m, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_left",  exp_q.size(), 0);
    chk("sbm_left", expm_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

`default_nettype wire
